// File: rtl/decode_stage1_pkg.sv
// Shared definitions for the stage-1 decoder: BPF opcode fields, PC select codes, FSM states.
package decode_stage1_pkg;

  localparam logic [2:0] ClsLd   = 3'h0;
  localparam logic [2:0] ClsLdx  = 3'h1;
  localparam logic [2:0] ClsSt   = 3'h2;
  localparam logic [2:0] ClsStx  = 3'h3;
  localparam logic [2:0] ClsAlu  = 3'h4;
  localparam logic [2:0] ClsJmp  = 3'h5;
  localparam logic [2:0] ClsRet  = 3'h6;
  localparam logic [2:0] ClsMisc = 3'h7;

  localparam logic [2:0] ModeImm = 3'h0;
  localparam logic [2:0] ModeAbs = 3'h1;
  localparam logic [2:0] ModeInd = 3'h2;
  localparam logic [2:0] ModeMem = 3'h3;
  localparam logic [2:0] ModeLen = 3'h4;
  localparam logic [2:0] ModeMsh = 3'h5;

  localparam logic [3:0] JmpOpJa = 4'h0;

  localparam logic [1:0] PcSelPlus1 = 2'b00;
  localparam logic [1:0] PcSelPlusK = 2'b01;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  function automatic logic [2:0] opc_class(input logic [7:0] opc);
    return opc[2:0];
  endfunction

  function automatic logic [2:0] opc_mode(input logic [7:0] opc);
    return opc[7:5];
  endfunction

endpackage

// File: rtl/decode_stage1_wait_ctr.sv
// Loadable down-counter timing the memory read latency while stage 1 sits in WAIT.
module stage1_wait_ctr #(
  parameter int unsigned CtrW = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic [CtrW-1:0] value_i,
  output logic            done_o
);

  logic [CtrW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CtrW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CtrW'(1));

endmodule

// File: rtl/decode_stage1.sv
// Stage-1 controller: issues packet/scratch reads, resolves JA, and hands a valid bit to stage 2.
module decode_stage1
  import decode_stage1_pkg::*;
#(
  parameter int unsigned PackmemRdLat = 2,
  parameter int unsigned ScratchRdLat = 1,
  parameter int unsigned CtrW         = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       stage0_valid_i,
  input  logic [7:0] opcode_i,
  input  logic       stage2_stalled_i,
  input  logic       stage2_pc_en_i,
  output logic       stage1_stalled_o,
  output logic       stage1_pc_en_o,
  output logic [1:0] pc_sel_o,
  output logic       packmem_rd_en_o,
  output logic       scratch_rd_en_o,
  output logic       valid_o
);

  state_e state_q, state_d;
  logic   valid_q, valid_d;
  logic   stalled, accept, is_ld, is_pack, is_scratch, is_ja;
  logic   ctr_load, ctr_done;
  logic [CtrW-1:0] ctr_value;
  logic   unused_src;

  assign unused_src = opcode_i[3];

  assign is_ld      = (opc_class(opcode_i) == ClsLd) || (opc_class(opcode_i) == ClsLdx);
  assign is_pack    = is_ld && ((opc_mode(opcode_i) == ModeAbs) ||
                                (opc_mode(opcode_i) == ModeInd) ||
                                (opc_mode(opcode_i) == ModeMsh));
  assign is_scratch = is_ld && (opc_mode(opcode_i) == ModeMem);
  assign is_ja      = (opc_class(opcode_i) == ClsJmp) && (opcode_i[7:4] == JmpOpJa);

  assign stalled = (state_q == StWait) || (valid_q && stage2_stalled_i);
  assign accept  = !rst_i && stage0_valid_i && !stalled && !stage2_pc_en_i;

  assign stage1_stalled_o = !rst_i && stalled;
  assign packmem_rd_en_o  = accept && (state_q == StIdle) && is_pack;
  assign scratch_rd_en_o  = accept && (state_q == StIdle) && is_scratch;
  assign stage1_pc_en_o   = accept && (state_q == StIdle) && is_ja;
  assign pc_sel_o         = stage1_pc_en_o ? PcSelPlusK : PcSelPlus1;
  assign valid_o          = valid_q;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q && stage2_stalled_i;
    ctr_load  = 1'b0;
    ctr_value = '0;
    if (stage2_pc_en_i) begin
      // Squash wins over the hold; any in-flight read data is dropped.
      state_d = StIdle;
      valid_d = 1'b0;
    end else if (state_q == StWait) begin
      if (ctr_done) begin
        state_d = StIdle;
        valid_d = 1'b1;
      end
    end else if (accept) begin
      if (is_pack) begin
        if (PackmemRdLat == 1) begin
          valid_d = 1'b1;
        end else begin
          state_d   = StWait;
          valid_d   = 1'b0;
          ctr_load  = 1'b1;
          ctr_value = CtrW'(PackmemRdLat - 1);
        end
      end else if (is_scratch) begin
        if (ScratchRdLat == 1) begin
          valid_d = 1'b1;
        end else begin
          state_d   = StWait;
          valid_d   = 1'b0;
          ctr_load  = 1'b1;
          ctr_value = CtrW'(ScratchRdLat - 1);
        end
      end else begin
        valid_d = !is_ja;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  stage1_wait_ctr #(
    .CtrW(CtrW)
  ) u_wait_ctr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (stage2_pc_en_i),
    .load_i  (ctr_load),
    .value_i (ctr_value),
    .done_o  (ctr_done)
  );

endmodule
